// File: rtl/ureg_serial_loader.sv
// Serial loader for a universal shift register chain.
// It accepts a parallel word over a valid/ready handshake and shifts it out on SDL (left) or SDR (right).
module ureg_serial_loader #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             CLRb,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             abort,
    output logic             S1,
    output logic             S0,
    output logic             SDL,
    output logic             SDR,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] shadow;
    logic            sdir;

    logic [CW-1:0]   nxt_cnt;
    logic [CW-1:0]   lsb_idx;

    // Index of the bit shown after this edge; the right path walks the word from the LSB upward
    always_comb begin
        nxt_cnt = cnt - CW'(1);
        lsb_idx = CW'(WIDTH - 1) - nxt_cnt;
    end

    always_ff @(posedge clk or negedge CLRb) begin
        if (!CLRb) begin
            state       <= IDLE;
            cnt         <= '0;
            shadow      <= '0;
            sdir        <= 1'b0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            S1          <= 1'b0;
            S0          <= 1'b0;
            SDL         <= 1'b0;
            SDR         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start_valid) begin
                        // The first bit goes out on the handshake edge itself
                        state       <= SHIFT;
                        shadow      <= data_in;
                        sdir        <= dir;
                        cnt         <= CW'(WIDTH - 1);
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        S1          <= dir;
                        S0          <= ~dir;
                        SDL         <= dir ? 1'b0 : data_in[WIDTH-1];
                        SDR         <= dir ? data_in[0] : 1'b0;
                    end
                end

                SHIFT: begin
                    if (abort) begin
                        state       <= IDLE;
                        start_ready <= 1'b1;
                        busy        <= 1'b0;
                        S1          <= 1'b0;
                        S0          <= 1'b0;
                        SDL         <= 1'b0;
                        SDR         <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        S1    <= 1'b0;
                        S0    <= 1'b0;
                        SDL   <= 1'b0;
                        SDR   <= 1'b0;
                    end else begin
                        cnt <= nxt_cnt;
                        SDL <= sdir ? 1'b0 : shadow[nxt_cnt];
                        SDR <= sdir ? shadow[lsb_idx] : 1'b0;
                    end
                end

                DONE: begin
                    state       <= IDLE;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                end

                default: begin
                    state       <= IDLE;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                    S1          <= 1'b0;
                    S0          <= 1'b0;
                    SDL         <= 1'b0;
                    SDR         <= 1'b0;
                end
            endcase
        end
    end

endmodule
